// File: rtl/vgm_axi_write_arbiter_if.sv
// Write-channel bundles for the two-requester AXI3 write arbiter: upstream
// requester port (3-bit IDs) and the shared downstream port (4-bit IDs).
interface vgm_axi_write_arbiter_if;
  logic [2:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

interface vgm_axi_write_arbiter_m_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awvalid, wid, wdata, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awvalid, wid, wdata, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/vgm_axi_write_arbiter.sv
// Two-requester AXI3 write arbiter: round-robin AW, W in grant order, B routed by ID.
// Optional burst-length checking is enabled by defining VGM_AXI_WRITE_ARBITER_LEN_CHECK_EN.
module vgm_axi_write_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  vgm_axi_write_arbiter_if.slave     s0,
  vgm_axi_write_arbiter_if.slave     s1,
  vgm_axi_write_arbiter_m_if.master  m,
  output logic                       len_err
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic             lock_sel;
  logic             rr;
  logic [DEPTH-1:0] fifo_sel;
  logic [2:0]       fifo_id [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       beat_cnt;
  logic             full_c, empty_c, sel_c, push_c;
  logic             head_c, w_hs_c, src_wlast_c, wlast_c, pop_c;
`ifdef VGM_AXI_WRITE_ARBITER_LEN_CHECK_EN
  logic [3:0]       fifo_len [DEPTH];
  logic             len_hit_c;
`endif

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);

  // AW grant: LOCK holds the saved requester, IDLE arbitrates round-robin
  always_comb begin
    sel_c = 1'b0;
    if (state == LOCK)                   sel_c = lock_sel;
    else if (s0.awvalid && s1.awvalid)   sel_c = rr;
    else                                 sel_c = s1.awvalid;
  end

  assign m.awid     = sel_c ? {1'b1, s1.awid} : {1'b0, s0.awid};
  assign m.awaddr   = sel_c ? s1.awaddr : s0.awaddr;
  assign m.awlen    = sel_c ? s1.awlen  : s0.awlen;
  assign m.awvalid  = !full_c && (sel_c ? s1.awvalid : s0.awvalid);
  assign s0.awready = m.awvalid && !sel_c && m.awready;
  assign s1.awready = m.awvalid &&  sel_c && m.awready;
  assign push_c     = m.awvalid && m.awready;

  // W path follows the FIFO head; the other requester is stalled
  assign head_c      = fifo_sel[rd_ptr];
  assign m.wid       = {head_c, fifo_id[rd_ptr]};
  assign m.wdata     = head_c ? s1.wdata : s0.wdata;
  assign m.wvalid    = !empty_c && (head_c ? s1.wvalid : s0.wvalid);
  assign s0.wready   = !empty_c && !head_c && m.wready;
  assign s1.wready   = !empty_c &&  head_c && m.wready;
  assign w_hs_c      = m.wvalid && m.wready;
  assign src_wlast_c = head_c ? s1.wlast : s0.wlast;

`ifdef VGM_AXI_WRITE_ARBITER_LEN_CHECK_EN
  assign len_hit_c = (beat_cnt == fifo_len[rd_ptr]);
  assign wlast_c   = len_hit_c;
`else
  assign wlast_c   = src_wlast_c;
  assign len_err   = 1'b0;
`endif
  assign m.wlast = wlast_c;
  assign pop_c   = w_hs_c && wlast_c;

  // B path: bit 3 of the downstream ID names the requester
  assign s0.bvalid = m.bvalid && !m.bid[3];
  assign s1.bvalid = m.bvalid &&  m.bid[3];
  assign s0.bid    = m.bid[2:0];
  assign s1.bid    = m.bid[2:0];
  assign s0.bresp  = m.bresp;
  assign s1.bresp  = m.bresp;
  assign m.bready  = m.bid[3] ? s1.bready : s0.bready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      lock_sel <= 1'b0;
      rr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push_c) begin
            rr <= ~sel_c;
          end else if (m.awvalid) begin
            state    <= LOCK;
            lock_sel <= sel_c;
          end
        end
        LOCK: begin
          if (push_c) begin
            rr    <= ~lock_sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_c) begin
      fifo_sel[wr_ptr] <= sel_c;
      fifo_id[wr_ptr]  <= sel_c ? s1.awid : s0.awid;
`ifdef VGM_AXI_WRITE_ARBITER_LEN_CHECK_EN
      fifo_len[wr_ptr] <= m.awlen;
`endif
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
      if (pop_c)       beat_cnt <= '0;
      else if (w_hs_c) beat_cnt <= beat_cnt + 4'd1;
    end
  end

`ifdef VGM_AXI_WRITE_ARBITER_LEN_CHECK_EN
  // Sticky flag: requester WLAST disagrees with the beat count
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                                   len_err <= 1'b0;
    else if (w_hs_c && (src_wlast_c != len_hit_c)) len_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_vgm_axi_write_arbiter.sv
// Scoreboard bench for vgm_axi_write_arbiter: directed stimulus pushes expected
// AW/W/B transfers into queues; a negedge monitor pops and compares on handshakes.
module tb_vgm_axi_write_arbiter;
  logic ACLK = 1'b0;
  logic ARESET;
  logic len_err;

  vgm_axi_write_arbiter_if   s0 ();
  vgm_axi_write_arbiter_if   s1 ();
  vgm_axi_write_arbiter_m_if m ();

  vgm_axi_write_arbiter #(.DEPTH(4)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .s0      (s0),
    .s1      (s1),
    .m       (m),
    .len_err (len_err)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_aw [$];
  logic [63:0] exp_w  [$];
  logic [63:0] exp_b0 [$];
  logic [63:0] exp_b1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event without a matching expectation or wait expired", name);
  endtask

  // Monitor: compare every handshake against the head of its queue
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (m.awvalid && m.awready) begin
        if (exp_aw.size() == 0) flag("aw_unexpected");
        else check("aw_xfer", 64'({m.awid, m.awaddr, m.awlen}), exp_aw.pop_front());
      end
      if (m.wvalid && m.wready) begin
        if (exp_w.size() == 0) flag("w_unexpected");
        else check("w_xfer", 64'({m.wid, m.wdata, m.wlast}), exp_w.pop_front());
      end
      if (s0.bvalid && s0.bready) begin
        if (exp_b0.size() == 0) flag("b0_unexpected");
        else check("b0_xfer", 64'({s0.bid, s0.bresp}), exp_b0.pop_front());
      end
      if (s1.bvalid && s1.bready) begin
        if (exp_b1.size() == 0) flag("b1_unexpected");
        else check("b1_xfer", 64'({s1.bid, s1.bresp}), exp_b1.pop_front());
      end
    end
  end

  task automatic init_inputs();
    s0.awid = '0; s0.awaddr = '0; s0.awlen = '0; s0.awvalid = 1'b0;
    s0.wdata = '0; s0.wlast = 1'b0; s0.wvalid = 1'b0; s0.bready = 1'b0;
    s1.awid = '0; s1.awaddr = '0; s1.awlen = '0; s1.awvalid = 1'b0;
    s1.wdata = '0; s1.wlast = 1'b0; s1.wvalid = 1'b0; s1.bready = 1'b0;
    m.awready = 1'b0; m.wready = 1'b0;
    m.bid = '0; m.bresp = '0; m.bvalid = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  task automatic aw_send(input bit n, input logic [2:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
    int   k;
    logic rdy;
    if (n) begin s1.awid = id; s1.awaddr = addr; s1.awlen = len; s1.awvalid = 1'b1; end
    else   begin s0.awid = id; s0.awaddr = addr; s0.awlen = len; s0.awvalid = 1'b1; end
    k = 0;
    do begin
      @(negedge ACLK);
      rdy = n ? s1.awready : s0.awready;
      k++;
    end while (!rdy && k < 200);
    if (!rdy) flag("aw_timeout");
    @(posedge ACLK);
    #1;
    if (n) s1.awvalid = 1'b0; else s0.awvalid = 1'b0;
  endtask

  task automatic w_send(input bit n, input logic [31:0] data, input logic last);
    int   k;
    logic rdy;
    if (n) begin s1.wdata = data; s1.wlast = last; s1.wvalid = 1'b1; end
    else   begin s0.wdata = data; s0.wlast = last; s0.wvalid = 1'b1; end
    k = 0;
    do begin
      @(negedge ACLK);
      rdy = n ? s1.wready : s0.wready;
      k++;
    end while (!rdy && k < 200);
    if (!rdy) flag("w_timeout");
    @(posedge ACLK);
    #1;
    if (n) s1.wvalid = 1'b0; else s0.wvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    init_inputs();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_m_awvalid", 64'(m.awvalid), 64'(0));
    check("rst_m_wvalid",  64'(m.wvalid),  64'(0));
    check("rst_s0_wready", 64'(s0.wready), 64'(0));
    check("rst_len_err",   64'(len_err),   64'(0));
    ARESET = 1'b0;

    // Single s0 burst: ID 3, addr 0x1000, len 3
    m.awready = 1'b1; m.wready = 1'b1; s0.bready = 1'b1; s1.bready = 1'b1;
    exp_aw.push_back(64'({4'h3, 32'h0000_1000, 4'd3}));
    fork
      aw_send(1'b0, 3'd3, 32'h0000_1000, 4'd3);
      begin
        @(negedge ACLK);
        check("t1_awid_same_cycle", 64'(m.awid), 64'(4'h3));
        check("t1_s0_awready", 64'(s0.awready), 64'(1));
      end
    join
    for (int i = 0; i < 4; i++) begin
      exp_w.push_back(64'({4'h3, 32'hA000_0000 + 32'(i), (i == 3)}));
      w_send(1'b0, 32'hA000_0000 + 32'(i), (i == 3));
    end
    s0.wvalid = 1'b1;
    @(negedge ACLK);
    check("t1_popped_s0_wready", 64'(s0.wready), 64'(0));
    check("t1_popped_m_wvalid",  64'(m.wvalid),  64'(0));
    @(posedge ACLK);
    #1 s0.wvalid = 1'b0;
    exp_b0.push_back(64'({3'd3, 2'b00}));
    m.bid = 4'h3; m.bresp = 2'b00; m.bvalid = 1'b1;
    @(negedge ACLK);
    check("t1_s1_bvalid", 64'(s1.bvalid), 64'(0));
    check("t1_s0_bvalid", 64'(s0.bvalid), 64'(1));
    @(posedge ACLK);
    #1 m.bvalid = 1'b0;

    // Round-robin from reset: s0, s1, s0, s1
    do_reset();
    exp_aw.push_back(64'({4'h1, 32'h0000_0100, 4'd0}));
    exp_aw.push_back(64'({4'hA, 32'h0000_0200, 4'd0}));
    exp_aw.push_back(64'({4'h3, 32'h0000_0300, 4'd0}));
    exp_aw.push_back(64'({4'hC, 32'h0000_0400, 4'd0}));
    fork
      begin aw_send(1'b0, 3'd1, 32'h100, 4'd0); aw_send(1'b0, 3'd3, 32'h300, 4'd0); end
      begin aw_send(1'b1, 3'd2, 32'h200, 4'd0); aw_send(1'b1, 3'd4, 32'h400, 4'd0); end
    join
    exp_w.push_back(64'({4'h1, 32'hD1, 1'b1}));
    exp_w.push_back(64'({4'hA, 32'hD2, 1'b1}));
    exp_w.push_back(64'({4'h3, 32'hD3, 1'b1}));
    exp_w.push_back(64'({4'hC, 32'hD4, 1'b1}));
    fork
      begin w_send(1'b0, 32'hD1, 1'b1); w_send(1'b0, 32'hD3, 1'b1); end
      begin w_send(1'b1, 32'hD2, 1'b1); w_send(1'b1, 32'hD4, 1'b1); end
    join

    // LOCK: s1 stalled by AWREADY low, s0 arrives later but must wait
    m.awready = 1'b0;
    exp_aw.push_back(64'({4'hD, 32'h0000_2000, 4'd0}));
    exp_aw.push_back(64'({4'h1, 32'h0000_3000, 4'd0}));
    fork
      aw_send(1'b1, 3'd5, 32'h2000, 4'd0);
      begin @(posedge ACLK); #1; aw_send(1'b0, 3'd1, 32'h3000, 4'd0); end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge ACLK);
          check("t3_lock_awid", 64'(m.awid), 64'(4'hD));
        end
        @(posedge ACLK);
        #1 m.awready = 1'b1;
      end
    join
    exp_w.push_back(64'({4'hD, 32'hE1, 1'b1}));
    exp_w.push_back(64'({4'h1, 32'hE2, 1'b1}));
    w_send(1'b1, 32'hE1, 1'b1);
    w_send(1'b0, 32'hE2, 1'b1);

    // FIFO full: fifth AW held until the first WLAST handshake
    m.wready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_aw.push_back(64'({1'b0, 3'(k), 32'h4000 + 32'(4 * k), 4'd0}));
      exp_w.push_back(64'({1'b0, 3'(k), 32'hB0 + 32'(k), 1'b1}));
    end
    fork
      for (int k = 0; k < 5; k++) aw_send(1'b0, 3'(k), 32'h4000 + 32'(4 * k), 4'd0);
      begin
        repeat (8) @(posedge ACLK);
        @(negedge ACLK);
        check("t4_full_s0_awready", 64'(s0.awready), 64'(0));
        check("t4_full_m_awvalid",  64'(m.awvalid),  64'(0));
        @(posedge ACLK);
        #1 m.wready = 1'b1;
        for (int k = 0; k < 5; k++) w_send(1'b0, 32'hB0 + 32'(k), 1'b1);
      end
    join

    // No interleave: s1 W waits for the whole s0 burst
    exp_aw.push_back(64'({4'h6, 32'h0000_5000, 4'd2}));
    exp_aw.push_back(64'({4'hF, 32'h0000_6000, 4'd0}));
    aw_send(1'b0, 3'd6, 32'h5000, 4'd2);
    aw_send(1'b1, 3'd7, 32'h6000, 4'd0);
    exp_w.push_back(64'({4'h6, 32'hF0, 1'b0}));
    exp_w.push_back(64'({4'h6, 32'hF1, 1'b0}));
    exp_w.push_back(64'({4'h6, 32'hF2, 1'b1}));
    exp_w.push_back(64'({4'hF, 32'hF3, 1'b1}));
    fork
      w_send(1'b1, 32'hF3, 1'b1);
      begin
        w_send(1'b0, 32'hF0, 1'b0);
        @(negedge ACLK);
        check("t5_s1_wready_blocked", 64'(s1.wready), 64'(0));
        check("t5_m_wvalid_gap",      64'(m.wvalid),  64'(0));
        @(posedge ACLK);
        #1;
        w_send(1'b0, 32'hF1, 1'b0);
        w_send(1'b0, 32'hF2, 1'b1);
      end
    join

    // B routed to s1, BREADY taken from s1
    s1.bready = 1'b0;
    exp_b1.push_back(64'({3'd6, 2'b10}));
    m.bid = 4'hE; m.bresp = 2'b10; m.bvalid = 1'b1;
    @(negedge ACLK);
    check("t6_m_bready_from_s1", 64'(m.bready),  64'(0));
    check("t6_s0_bvalid",        64'(s0.bvalid), 64'(0));
    check("t6_s1_bvalid",        64'(s1.bvalid), 64'(1));
    @(posedge ACLK);
    #1 s1.bready = 1'b1;
    @(negedge ACLK);
    check("t6_m_bready_high", 64'(m.bready), 64'(1));
    @(posedge ACLK);
    #1 m.bvalid = 1'b0;

`ifdef VGM_AXI_WRITE_ARBITER_LEN_CHECK_EN
    // Early WLAST with AWLEN=1: flag sticks, m_WLAST follows the count
    exp_aw.push_back(64'({4'h2, 32'h0000_7000, 4'd1}));
    aw_send(1'b0, 3'd2, 32'h7000, 4'd1);
    exp_w.push_back(64'({4'h2, 32'hC0, 1'b0}));
    exp_w.push_back(64'({4'h2, 32'hC1, 1'b1}));
    w_send(1'b0, 32'hC0, 1'b1);
    @(negedge ACLK);
    check("t7_len_err_set", 64'(len_err), 64'(1));
    @(posedge ACLK);
    #1;
    w_send(1'b0, 32'hC1, 1'b0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("t7_len_err_sticky", 64'(len_err), 64'(1));
`else
    @(negedge ACLK);
    check("len_err_tied_low", 64'(len_err), 64'(0));
`endif

    repeat (2) @(posedge ACLK);
    check("left_aw", 64'(exp_aw.size()), 64'(0));
    check("left_w",  64'(exp_w.size()),  64'(0));
    check("left_b0", 64'(exp_b0.size()), 64'(0));
    check("left_b1", 64'(exp_b1.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
